// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: drives i2cMaster's Avalon register map so a requester can
// perform single-register I2C writes and reads through a simple req/resp port.
module i2c_reg_sequencer #(
    parameter int unsigned TIMEOUT_CLK = 200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic       reqRnw,
    input  logic [6:0] reqDevAdr,
    input  logic [7:0] reqRegAdr,
    input  logic [7:0] reqWrData,
    output logic       respValid,
    output logic [7:0] respRdData,
    output logic [1:0] respErr,
    output logic [1:0] avsAdr,
    output logic       avsWr,
    output logic [7:0] avsWrData,
    output logic       avsRd,
    input  logic [7:0] avsRdData,
    input  logic       insIrq
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLK - 1);

    typedef enum logic [3:0] {
        S_RST, S_INIT0, S_GAP0, S_GAP1,
        S_INIT1, S_IDLE, S_LDAT, S_LCMD,
        S_WAIT, S_CLR, S_RDST, S_CHK,
        S_FRD, S_FCAP, S_RESP, S_ABORT
    } state_e;

    state_e      state_q, state_d;
    logic        rnw_q, rnw_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wd_q, wd_d;
    logic [1:0]  step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  rd_q, rd_d;
    logic [1:0]  err_q, err_d;

    logic [7:0]  byte_data;
    logic [7:0]  byte_cmd;
    logic        last_step;

    // Byte command table: write = 3 steps, read = 4 steps
    always_comb begin
        byte_data = 8'h00;
        byte_cmd  = 8'h00;
        unique case (step_q)
            2'd0: begin
                byte_data = {dev_q, 1'b0};
                byte_cmd  = 8'hC0;
            end
            2'd1: begin
                byte_data = reg_q;
                byte_cmd  = 8'h40;
            end
            2'd2: begin
                if (rnw_q) begin
                    byte_data = {dev_q, 1'b1};
                    byte_cmd  = 8'hC0;
                end else begin
                    byte_data = wd_q;
                    byte_cmd  = 8'h50;
                end
            end
            default: begin
                byte_data = 8'h00;
                byte_cmd  = 8'h10;
            end
        endcase
    end

    assign last_step = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            rnw_q   <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wd_q    <= 8'h00;
            step_q  <= 2'd0;
            cnt_q   <= 32'd0;
            rd_q    <= 8'h00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            rnw_q   <= rnw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wd_q    <= wd_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wd_d    = wd_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = err_q;
        unique case (state_q)
            S_RST:   state_d = S_INIT0;
            S_INIT0: state_d = S_GAP0;
            S_GAP0:  state_d = S_GAP1;
            S_GAP1:  state_d = S_INIT1;
            S_INIT1: state_d = S_IDLE;
            S_IDLE: begin
                if (reqValid) begin
                    rnw_d   = reqRnw;
                    dev_d   = reqDevAdr;
                    reg_d   = reqRegAdr;
                    wd_d    = reqWrData;
                    step_d  = 2'd0;
                    cnt_d   = 32'd0;
                    state_d = S_LDAT;
                end
            end
            S_LDAT:  state_d = S_LCMD;
            S_LCMD: begin
                cnt_d   = 32'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (insIrq) begin
                    state_d = S_CLR;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 2'b10;
                    state_d = S_ABORT;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CLR:   state_d = S_RDST;
            S_RDST:  state_d = S_CHK;
            S_CHK: begin
                if (avsRdData[1:0] != 2'b00) begin
                    err_d   = 2'b01;
                    state_d = S_ABORT;
                end else if (!last_step) begin
                    step_d  = step_q + 2'd1;
                    state_d = S_LDAT;
                end else if (rnw_q) begin
                    state_d = S_FRD;
                end else begin
                    err_d   = 2'b00;
                    state_d = S_RESP;
                end
            end
            S_FRD:   state_d = S_FCAP;
            S_FCAP: begin
                rd_d    = avsRdData;
                err_d   = 2'b00;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            // Soft reset via re-init frees a bus left mid-transfer
            S_ABORT: state_d = S_INIT0;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        reqReady  = 1'b0;
        respValid = 1'b0;
        avsAdr    = 2'd0;
        avsWr     = 1'b0;
        avsWrData = 8'h00;
        avsRd     = 1'b0;
        unique case (state_q)
            S_INIT0: begin
                avsWr     = 1'b1;
                avsAdr    = 2'd0;
                avsWrData = 8'h01;
            end
            S_INIT1: begin
                avsWr     = 1'b1;
                avsAdr    = 2'd0;
                avsWrData = 8'hC0;
            end
            S_IDLE:  reqReady = 1'b1;
            S_LDAT: begin
                avsWr     = 1'b1;
                avsAdr    = 2'd2;
                avsWrData = byte_data;
            end
            S_LCMD: begin
                avsWr     = 1'b1;
                avsAdr    = 2'd3;
                avsWrData = byte_cmd;
            end
            S_CLR: begin
                avsWr     = 1'b1;
                avsAdr    = 2'd1;
                avsWrData = 8'h00;
            end
            S_RDST: begin
                avsRd  = 1'b1;
                avsAdr = 2'd3;
            end
            S_FRD: begin
                avsRd  = 1'b1;
                avsAdr = 2'd2;
            end
            S_RESP:  respValid = 1'b1;
            S_ABORT: respValid = 1'b1;
            default: ;
        endcase
    end

    assign respRdData = rd_q;
    assign respErr    = err_q;

endmodule
